prime_mul_gen: RTL



---
 rtl/prime_mul_gen_if.sv | 26 ++
 rtl/prime_mul_gen.sv | 102 ++++++++++
 2 files changed

// File: rtl/prime_mul_gen_if.sv
// Operand/product handshake bundle between the multiplier and its neighbours.
// The master end supplies operands and consumes c; the slave end is the multiplier.
interface prime_mul_gen_if #(
    parameter int A_W = 24,
    parameter int B_W = 18,
    parameter int C_W = A_W + B_W
);
    logic           in_valid;
    logic           in_ready;
    logic [A_W-1:0] a;
    logic [B_W-1:0] b;
    logic           out_valid;
    logic           out_ready;
    logic [C_W-1:0] c;
    logic           busy;

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, c, busy
    );

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, c, busy
    );
endinterface

// File: rtl/prime_mul_gen.sv
// Shift-add a*b multiplier feeding the p = 2^24-63 reducer; B_W cycles from accept to out_valid.
// Holds c/out_valid while out_ready is low; in_ready stays low until the product is taken.
module prime_mul_gen #(
    parameter int A_W = 24,
    parameter int B_W = 18,
    parameter int C_W = A_W + B_W
) (
    input  logic           clk,
    input  logic           rst_n,
    prime_mul_gen_if.slave mul_if
);
    localparam int CNT_W = $clog2(B_W);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [A_W-1:0]   a_q, a_d;
    logic [B_W-1:0]   b_q, b_d;
    logic [C_W-1:0]   acc_q, acc_d;
    logic [C_W-1:0]   c_q, c_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [C_W-1:0]   partial;
    logic [C_W-1:0]   acc_sum;
    logic             last_step;
    logic             accept;
    logic             drain;

    assign accept    = (state_q == IDLE) && mul_if.in_valid;
    assign drain     = (state_q == DONE) && mul_if.out_ready;
    assign last_step = (cnt_q == CNT_W'(B_W - 1));
    assign partial   = b_q[0] ? (C_W'(a_q) << cnt_q) : '0;
    assign acc_sum   = acc_q + partial;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (accept) state_d = MUL;
            MUL:     if (last_step) state_d = DONE;
            DONE:    if (drain) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Handshake outputs decode the state register only, so no input reaches them combinationally.
    always_comb begin
        mul_if.in_ready  = (state_q == IDLE);
        mul_if.out_valid = (state_q == DONE);
        mul_if.busy      = (state_q == MUL) || (state_q == DONE);
    end

    always_comb begin
        a_d   = a_q;
        b_d   = b_q;
        acc_d = acc_q;
        cnt_d = cnt_q;
        c_d   = c_q;
        if (accept) begin
            a_d   = mul_if.a;
            b_d   = mul_if.b;
            acc_d = '0;
            cnt_d = '0;
        end else if (state_q == MUL) begin
            acc_d = acc_sum;
            b_d   = b_q >> 1;
            cnt_d = cnt_q + CNT_W'(1);
            if (last_step) begin
                c_d = acc_sum;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q   <= '0;
            b_q   <= '0;
            acc_q <= '0;
            cnt_q <= '0;
            c_q   <= '0;
        end else begin
            a_q   <= a_d;
            b_q   <= b_d;
            acc_q <= acc_d;
            cnt_q <= cnt_d;
            c_q   <= c_d;
        end
    end

    assign mul_if.c = c_q;
endmodule
